// File: rtl/ddr_write_sink.sv
// ---------------------------------------------------------------------------
// ddr_write_sink
//
// Single-clock stand-in for the board memory write path. The board system
// clock is re-exported as ui_clk. After reset the block counts out an
// initialisation/calibration period. When that period ends it raises
// c0_init_calib_complete. From then on it stores one DATA_W-bit word per
// cycle, while wr_en is high, into an internal array. Words go to
// sequential addresses, and the address wraps at DEPTH.
//
// Optional feature (compile-time macro DDR_WRITE_SINK_READBACK_EN):
//   adds a registered read port (rd_addr in, rd_data out). The read has a
//   1-cycle latency. A read and a write to the same address in the same
//   cycle return the old data. Without the macro the array is write-only.
//
// Ports:
//   user_si570_sysclk_clk_p  in   clock; all logic on its rising edge
//   user_si570_sysclk_clk_n  in   clock complement; unused
//   rst_n                    in   asynchronous active-low reset
//   reset                    in   synchronous active-high soft reset
//   ui_clk                   out  feed-through of user_si570_sysclk_clk_p
//   din                      in   write data (DATA_W bits)
//   wr_en                    in   write strobe, one word per cycle
//   c0_init_calib_complete   out  high once writes are accepted
//   wr_ptr                   out  address used by the next accepted write
//   wr_count                 out  accepted writes since reset, saturating
//   rd_addr / rd_data             readback port (macro builds only)
// ---------------------------------------------------------------------------
module ddr_write_sink #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 1024,
  parameter int CALIB_CYCLES = 1000
) (
  input  logic                     user_si570_sysclk_clk_p,
  input  logic                     rst_n,
  input  logic                     user_si570_sysclk_clk_n,
  input  logic                     reset,
  output logic                     ui_clk,
  input  logic [DATA_W-1:0]        din,
  input  logic                     wr_en,
  output logic                     c0_init_calib_complete,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
`ifdef DDR_WRITE_SINK_READBACK_EN
  output logic [15:0]              wr_count,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
`else
  output logic [15:0]              wr_count
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  // The counter only has to hold 0 .. CALIB_CYCLES-1.
  localparam int CNT_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALIB_CYCLES - 1);

  logic              clk;
  logic              unused_clk_n;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              calib_q, calib_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              wr_accept;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign clk          = user_si570_sysclk_clk_p;
  assign ui_clk       = user_si570_sysclk_clk_p;
  assign unused_clk_n = user_si570_sysclk_clk_n;

  // The soft reset blocks acceptance, so it has priority over wr_en.
  assign wr_accept = wr_en & calib_q & ~reset;

  always_comb begin
    cnt_d      = cnt_q;
    calib_d    = calib_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    if (reset) begin
      cnt_d      = '0;
      calib_d    = 1'b0;
      wr_ptr_d   = '0;
      wr_count_d = '0;
    end else begin
      // When the counter reaches its last value it freezes there, and the
      // done flag stays high until the next reset.
      if (!calib_q) begin
        if (cnt_q == CNT_LAST) begin
          calib_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (wr_accept) begin
        // DEPTH is a power of two, so the natural overflow wraps to 0.
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (wr_count_q != 16'hFFFF) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      calib_q    <= 1'b0;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      calib_q    <= calib_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  // The array has no reset; words survive both kinds of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

`ifdef DDR_WRITE_SINK_READBACK_EN
  logic [DATA_W-1:0] rd_data_q;

  // This non-blocking read samples the array before a same-edge write
  // lands, so a read and a write to the same address return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign c0_init_calib_complete = calib_q;
  assign wr_ptr                 = wr_ptr_q;
  assign wr_count               = wr_count_q;

endmodule

// File: tb/tb_ddr_write_sink.sv
`timescale 1ns/1ps
module tb_ddr_write_sink;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 1024;
  localparam int CALIB  = 1000;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk_p;
  logic              clk_n;
  logic              rst_n;
  logic              reset;
  logic              ui_clk;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              calib;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       wr_count;
`ifdef DDR_WRITE_SINK_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
`endif

  int n_assert;
  int n_fail;
  int n;

  ddr_write_sink #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .CALIB_CYCLES(CALIB)
  ) dut (
    .user_si570_sysclk_clk_p(clk_p),
    .rst_n                  (rst_n),
    .user_si570_sysclk_clk_n(clk_n),
    .reset                  (reset),
    .ui_clk                 (ui_clk),
    .din                    (din),
    .wr_en                  (wr_en),
    .c0_init_calib_complete (calib),
    .wr_ptr                 (wr_ptr),
`ifdef DDR_WRITE_SINK_READBACK_EN
    .wr_count               (wr_count),
    .rd_addr                (rd_addr),
    .rd_data                (rd_data)
`else
    .wr_count               (wr_count)
`endif
  );

  // 150 MHz clock
  initial begin
    clk_p = 1'b0;
    forever #3.333 clk_p = ~clk_p;
  end
  assign clk_n = ~clk_p;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_calib(output int cycles);
    cycles = 0;
    while (calib !== 1'b1 && cycles < 2 * CALIB) begin
      @(posedge clk_p);
      #1;
      cycles++;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    din      = '0;
`ifdef DDR_WRITE_SINK_READBACK_EN
    rd_addr  = '0;
`endif

    // Reset state while rst_n is low
    #30;
    chk("rst_calib", calib, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("ui_clk_track_rst", ui_clk, clk_p);

    // Release rst_n at 66 ns and reset at 366 ns; write strobes during calibration
    #36;
    rst_n = 1'b1;
    #300;
    reset = 1'b0;
    wr_en = 1'b1;
    din   = 128'd7;
    wait_calib(n);
    chk("calib_latency", n, CALIB);
    chk("early_wr_ptr", wr_ptr, 0);
    chk("early_wr_count", wr_count, 0);
    wr_en = 1'b0;
    chk("ui_clk_high", ui_clk, 1);
    @(negedge clk_p);
    #1;
    chk("ui_clk_low", ui_clk, 0);

    // Stream 1..500
    for (int i = 1; i <= 500; i++) begin
      din   = 128'(i);
      wr_en = 1'b1;
      @(posedge clk_p);
      #1;
    end
    wr_en = 1'b0;
    chk("stream_wr_ptr", wr_ptr, 500);
    chk("stream_wr_count", wr_count, 500);
    @(posedge clk_p);
    #1;
    chk("idle_wr_ptr", wr_ptr, 500);
`ifdef DDR_WRITE_SINK_READBACK_EN
    rd_addr = ADDR_W'(0);
    @(posedge clk_p);
    #1;
    chk("rd_mem0", rd_data, 1);
    rd_addr = ADDR_W'(499);
    @(posedge clk_p);
    #1;
    chk("rd_mem499", rd_data, 500);
`endif

    // Ten more writes, then a one-cycle soft reset with wr_en held high
    for (int i = 501; i <= 510; i++) begin
      din   = 128'(i);
      wr_en = 1'b1;
      @(posedge clk_p);
      #1;
    end
    chk("pre_sreset_count", wr_count, 510);
    reset = 1'b1;
    din   = 128'd999;
    @(posedge clk_p);
    #1;
    chk("sreset_calib", calib, 0);
    chk("sreset_wr_ptr", wr_ptr, 0);
    chk("sreset_wr_count", wr_count, 0);
    reset = 1'b0;
    wr_en = 1'b0;
    wait_calib(n);
    chk("recalib_latency", n, CALIB);
    chk("recalib_wr_ptr", wr_ptr, 0);
`ifdef DDR_WRITE_SINK_READBACK_EN
    rd_addr = ADDR_W'(505);
    @(posedge clk_p);
    #1;
    chk("rd_mem_intact", rd_data, 506);
`endif

    // Saturation and wrap: 70000 writes of 1..70000 from address 0
    for (int i = 1; i <= 70000; i++) begin
      din   = 128'(i);
      wr_en = 1'b1;
      @(posedge clk_p);
      #1;
    end
    wr_en = 1'b0;
    chk("sat_wr_count", wr_count, 65535);
    chk("wrap_wr_ptr", wr_ptr, 368);
`ifdef DDR_WRITE_SINK_READBACK_EN
    rd_addr = ADDR_W'(367);
    @(posedge clk_p);
    #1;
    chk("rd_wrap_367", rd_data, 70000);
    rd_addr = ADDR_W'(368);
    @(posedge clk_p);
    #1;
    chk("rd_wrap_368", rd_data, 68977);
`endif
    // One more write, to address 368, with a read of the same address
    din   = 128'd12345;
    wr_en = 1'b1;
    @(posedge clk_p);
    #1;
    wr_en = 1'b0;
    chk("sat_hold_count", wr_count, 65535);
    chk("post_wr_ptr", wr_ptr, 369);
`ifdef DDR_WRITE_SINK_READBACK_EN
    chk("rd_during_wr_old", rd_data, 68977);
    @(posedge clk_p);
    #1;
    chk("rd_after_wr_new", rd_data, 12345);
`endif

    // Assert rst_n between two clock edges
    @(posedge clk_p);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_calib", calib, 0);
    chk("arst_wr_ptr", wr_ptr, 0);
    chk("arst_wr_count", wr_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_write_sink.md
Name: ddr_write_sink

Overview:
- Single-clock model of the board memory write path wrapped for the top-level design.
- Re-exports the board system clock as `ui_clk` and runs an initialisation/calibration countdown.
- After calibration, accepts 128-bit words on a `wr_en`/`din` strobe and stores them sequentially into an internal memory array.
- Sits below the top-level harness that generates incrementing write data once `c0_init_calib_complete` rises.

Parameters:
- DATA_W, 128: width of `din` and of each memory word.
- DEPTH, 1024: number of memory words; must be a power of two, at least 2.
- CALIB_CYCLES, 1000: clock cycles from reset release to `c0_init_calib_complete`; must be at least 1.
- ADDR_W, clog2(DEPTH): localparam, not overridable.

Ports:
- user_si570_sysclk_clk_p  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- user_si570_sysclk_clk_n  in  1  complement of the clock input; accepted but unused internally.
- reset  in  1  synchronous active-high soft reset; restarts calibration.
- ui_clk  out  1  continuous assign of user_si570_sysclk_clk_p; no gating, no divide.
- din  in  DATA_W  write data.
- wr_en  in  1  write strobe, one word per cycle while high.
- c0_init_calib_complete  out  1  high when the block accepts writes.
- wr_ptr  out  ADDR_W  address the next accepted write uses.
- wr_count  out  16  accepted writes since the last reset; saturating.

Behaviour:
- Async reset (rst_n=0): immediately clears the calib counter, `c0_init_calib_complete`, `wr_ptr` and `wr_count` to 0. Memory contents are not reset.
- Sync reset (reset=1 at a rising edge, rst_n=1):
  - Same clears as async reset, taking effect at that edge.
  - Has priority over wr_en and over the calibration count.
- Calibration:
  - A counter starts at 0 on the first edge with rst_n=1 and reset=0.
  - It increments once per cycle.
  - `c0_init_calib_complete` is a registered output. It goes to 1 on the edge where the counter reaches CALIB_CYCLES-1, i.e. it is first high CALIB_CYCLES cycles after reset release.
  - It then stays 1, with the counter held, until a reset of either kind.
- Write acceptance: at a rising edge, a write is accepted when wr_en=1, c0_init_calib_complete=1 and reset=0. On acceptance:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, wrapping from DEPTH-1 to 0.
  - wr_count <= wr_count+1, saturating at 65535.
  - Latency: data is in the array after that same edge.
- wr_en while calibration is incomplete is ignored silently: no state change, no error flag.
- Wrap-around overwrites the oldest words silently; there is no full or backpressure indication.
- `din` and `wr_en` are don't-care when not accepted. X on din is stored as-is.
- No combinational path from inputs to outputs except the `ui_clk` feed-through.

Optional Feature:
- Macro DDR_WRITE_SINK_READBACK_EN.
- Defined: adds ports `rd_addr` (in, ADDR_W) and `rd_data` (out, DATA_W).
  - rd_data <= mem[rd_addr] every cycle: 1-cycle registered read, reset value 0.
  - Read-during-write to the same address returns the old data.
- Undefined: both ports absent; memory is write-only and may be trimmed by synthesis.

Test Plan:
- Reset/calib: rst_n=0 66 ns, reset=1 until 366 ns, 150 MHz clock, CALIB_CYCLES=1000 -> calib low until exactly 1000 cycles after reset falls, then high; ui_clk tracks clk_p.
- Early writes: wr_en=1, din=7 during calibration -> wr_ptr=0, wr_count=0 at calib rise.
- Stream: after calib, din=1..500 with wr_en=1 for 500 cycles, then wr_en=0 -> wr_ptr=500, wr_count=500. With readback, mem[0]=1 and mem[499]=500.
- Wrap: DEPTH=4, write 6 words A..F -> wr_ptr=2, mem[0]=E, mem[1]=F, mem[2]=C.
- Mid-stream sync reset: reset=1 for 1 cycle after 10 writes -> calib=0, wr_ptr=0, wr_count=0; calibration reruns for CALIB_CYCLES cycles; earlier memory data intact.
- Async reset mid-cycle: rst_n falls between edges -> outputs clear immediately without a clock edge; wr_count saturation check: 70000 writes -> 65535.
